// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard with tagged in-flight writes, per-instruction
// result latency and N-way operand bypass; raises stallreq on unresolved RAW hazards.
module id_scoreboard #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3,
  parameter int LW   = 2,
  parameter int TAGW = 3,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 issue_valid,
  input  logic                 issue_we,
  input  logic [AW-1:0]        issue_waddr,
  input  logic [LW-1:0]        issue_lat,
  output logic [TAGW-1:0]      issue_tag,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD*DW-1:0]    rf_rdata,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*TAGW-1:0] fwd_tag,
  input  logic [NFWD*DW-1:0]   fwd_data,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_waddr,
  input  logic [TAGW-1:0]      wb_tag,
  output logic [NRD*DW-1:0]    opnd,
  output logic                 stallreq,
  output logic [NREG-1:0]      busy_vec
);

  logic [NREG-1:0] busy;
  logic [LW-1:0]   cnt [NREG];
  logic [TAGW-1:0] tag [NREG];
  logic [TAGW-1:0] next_tag;
  logic            issue_fire;

  logic [AW-1:0]   raddr  [NRD];
  logic [DW-1:0]   rdat   [NRD];
  logic [DW-1:0]   opnd_a [NRD];
  logic [DW:0]     lk     [NRD];
  logic [NRD-1:0]  port_stall;
  logic [TAGW-1:0] ftag   [NFWD];
  logic [DW-1:0]   fdat   [NFWD];

  for (genvar p = 0; p < NRD; p++) begin : g_port
    assign raddr[p]            = rd_addr[p*AW +: AW];
    assign rdat[p]             = rf_rdata[p*DW +: DW];
    assign opnd[p*DW +: DW]    = opnd_a[p];
  end

  for (genvar c = 0; c < NFWD; c++) begin : g_chan
    assign ftag[c] = fwd_tag[c*TAGW +: TAGW];
    assign fdat[c] = fwd_data[c*DW +: DW];
  end

  // Returns {hit, data}; scanning oldest-to-youngest lets the youngest match win.
  function automatic logic [DW:0] fwd_lookup(input logic [TAGW-1:0] want);
    logic [DW:0] res;
    res = '0;
    for (int c = NFWD - 1; c >= 0; c--) begin
      if (fwd_valid[c] && ftag[c] == want) res = {1'b1, fdat[c]};
    end
    return res;
  endfunction

  assign issue_fire = issue_valid & adv & ~stallreq;
  assign issue_tag  = next_tag;
  assign busy_vec   = busy;
  assign stallreq   = |port_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      next_tag <= '0;
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
        tag[r] <= '0;
      end
    end else begin
      if (issue_fire) next_tag <= next_tag + TAGW'(1);
      for (int r = 1; r < NREG; r++) begin
        if (issue_fire && issue_we && issue_waddr == AW'(r)) begin
          busy[r] <= 1'b1;
          cnt[r]  <= issue_lat;
          tag[r]  <= next_tag;
        end else begin
          // A stale tag means a younger write superseded this one; keep the entry.
          if (wb_we && wb_waddr == AW'(r) && busy[r] && tag[r] == wb_tag)
            busy[r] <= 1'b0;
          if (adv && busy[r] && cnt[r] != '0)
            cnt[r] <= cnt[r] - LW'(1);
        end
      end
    end
  end

  always_comb begin
    port_stall = '0;
    for (int p = 0; p < NRD; p++) begin
      opnd_a[p] = rdat[p];
      lk[p]     = fwd_lookup(tag[raddr[p]]);
      if (rd_en[p]) begin
        if (raddr[p] == '0) begin
          opnd_a[p] = '0;
        end else if (busy[raddr[p]]) begin
          if (cnt[raddr[p]] == '0 && lk[p][DW])
            opnd_a[p] = lk[p][DW-1:0];
          else
            port_stall[p] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares against the DUT.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        adv;
  logic        issue_valid;
  logic        issue_we;
  logic [4:0]  issue_waddr;
  logic [1:0]  issue_lat;
  logic [2:0]  issue_tag;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rf_rdata;
  logic [2:0]  fwd_valid;
  logic [8:0]  fwd_tag;
  logic [95:0] fwd_data;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [2:0]  wb_tag;
  logic [63:0] opnd;
  logic        stallreq;
  logic [31:0] busy_vec;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .adv(adv),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_waddr(issue_waddr),
    .issue_lat(issue_lat), .issue_tag(issue_tag),
    .rd_en(rd_en), .rd_addr(rd_addr), .rf_rdata(rf_rdata),
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_tag(wb_tag),
    .opnd(opnd), .stallreq(stallreq), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] op;
    bit          chk_op;
    logic        st;
    logic [31:0] bv;
    logic [2:0]  it;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk_op) begin
        n_chk++;
        if (opnd[31:0] !== e.op) begin
          n_fail++;
          $display("FAIL %s opnd0 got %h want %h", e.name, opnd[31:0], e.op);
        end
      end
      n_chk++;
      if (opnd[63:32] !== 32'h0000_0BAD) begin
        n_fail++;
        $display("FAIL %s opnd1 got %h want %h", e.name, opnd[63:32], 32'h0000_0BAD);
      end
      n_chk++;
      if (stallreq !== e.st) begin
        n_fail++;
        $display("FAIL %s stallreq got %b want %b", e.name, stallreq, e.st);
      end
      n_chk++;
      if (busy_vec !== e.bv) begin
        n_fail++;
        $display("FAIL %s busy_vec got %h want %h", e.name, busy_vec, e.bv);
      end
      n_chk++;
      if (issue_tag !== e.it) begin
        n_fail++;
        $display("FAIL %s issue_tag got %0d want %0d", e.name, issue_tag, e.it);
      end
    end
  end

  task automatic push(input string nm, input logic [31:0] op, input bit chk,
                      input logic st, input logic [31:0] bv, input logic [2:0] it);
    exp_t e;
    e.name = nm; e.op = op; e.chk_op = chk; e.st = st; e.bv = bv; e.it = it;
    q.push_back(e);
  endtask

  task automatic idle();
    adv = 1'b1;
    issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0; issue_lat = '0;
    rd_en = '0; rd_addr = '0; rf_rdata = {32'h0000_0BAD, 32'h0};
    fwd_valid = '0; fwd_tag = '0; fwd_data = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_tag = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] a, input logic [1:0] l, input logic we);
    issue_valid = 1'b1; issue_we = we; issue_waddr = a; issue_lat = l;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] rf);
    rd_en[0] = 1'b1; rd_addr[4:0] = a; rf_rdata[31:0] = rf;
  endtask

  task automatic fwd(input int c, input logic [2:0] t, input logic [31:0] d);
    fwd_valid[c] = 1'b1; fwd_tag[c*3 +: 3] = t; fwd_data[c*32 +: 32] = d;
  endtask

  task automatic wb(input logic [4:0] a, input logic [2:0] t);
    wb_we = 1'b1; wb_waddr = a; wb_tag = t;
  endtask

  function automatic logic [31:0] b(input int n);
    return 32'h1 << n;
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    // reset held with live traffic
    tick(); issue(7, 2, 1); rd(7, 32'hAAAA);  push("rst_hold",    32'hAAAA, 1, 0, 0, 0);
    tick(); rst = 1'b1; rf_rdata[31:0] = 32'h5555; push("rst_release", 32'h5555, 1, 0, 0, 0);
    tick(); issue(7, 2, 1);                   push("issue_r7",    32'h0, 1, 0, 0, 0);
    tick();                                   push("r7_busy",     32'h0, 1, 0, b(7), 1);
    tick(); rst = 1'b0; rd(7, 32'h7777);      push("async_rst",   32'h7777, 1, 0, 0, 0);
    tick(); rst = 1'b1;                       push("rst_again",   32'h0, 1, 0, 0, 0);
    // ALU RAW, channel priority, WB-channel forward then regfile
    tick(); issue(5, 0, 1);                   push("alu_issue",   32'h0, 1, 0, 0, 0);
    tick(); rd(5, 32'hDEAD); fwd(0, 0, 32'h1234); fwd(2, 0, 32'h9999);
                                              push("alu_raw",     32'h1234, 1, 0, b(5), 1);
    tick(); rd(5, 32'hDEAD); fwd(2, 0, 32'h4321); wb(5, 0);
                                              push("wb_fwd",      32'h4321, 1, 0, b(5), 1);
    tick(); rd(5, 32'hBEEF);                  push("after_ret",   32'hBEEF, 1, 0, 0, 1);
    // load-use: one stall, issue blocked during stall
    tick(); issue(8, 1, 1);                   push("load_issue",  32'h0, 1, 0, 0, 1);
    tick(); issue(0, 0, 0); rd(8, 32'h1111); fwd(1, 1, 32'hCAFE);
                                              push("load_stall",  32'h0, 0, 1, b(8), 2);
    tick(); rd(8, 32'h1111); fwd(1, 1, 32'hCAFE); wb(8, 1);
                                              push("load_use",    32'hCAFE, 1, 0, b(8), 2);
    tick();                                   push("load_ret",    32'h0, 1, 0, 0, 2);
    // WAW: retire of superseded tag ignored
    tick(); issue(3, 0, 1);                   push("waw_a",       32'h0, 1, 0, 0, 2);
    tick(); issue(3, 0, 1);                   push("waw_b",       32'h0, 1, 0, b(3), 3);
    tick(); wb(3, 2);                         push("waw_old_wb",  32'h0, 1, 0, b(3), 4);
    tick(); rd(3, 32'h0); fwd(0, 2, 32'h2222); fwd(1, 3, 32'h3333); wb(3, 3);
                                              push("waw_keep",    32'h3333, 1, 0, b(3), 4);
    tick();                                   push("waw_new_wb",  32'h0, 1, 0, 0, 4);
    // same-cycle issue and retire to one register: issue wins
    tick(); issue(4, 0, 1);                   push("ir_a",        32'h0, 1, 0, 0, 4);
    tick(); issue(4, 1, 1); wb(4, 4);         push("ir_both",     32'h0, 1, 0, b(4), 5);
    tick(); rd(4, 32'h0);                     push("ir_stall",    32'h0, 0, 1, b(4), 6);
    tick(); rd(4, 32'h0); fwd(2, 5, 32'h5A5A); wb(4, 5);
                                              push("ir_fwd",      32'h5A5A, 1, 0, b(4), 6);
    // register 0 is never tracked
    tick(); issue(0, 2, 1); rd(0, 32'hFFFF);  push("r0_issue",    32'h0, 1, 0, 0, 6);
    tick(); rd(0, 32'hFFFF);                  push("r0_read",     32'h0, 1, 0, 0, 7);
    // tag wrap and adv=0 holding the latency counter
    tick(); issue(9, 2, 1);                   push("wrap_issue",  32'h0, 1, 0, 0, 7);
    tick(); adv = 1'b0; issue(10, 0, 1); rd(9, 32'h0); fwd(0, 7, 32'h9090);
                                              push("hold_1",      32'h0, 0, 1, b(9), 0);
    tick(); adv = 1'b0; issue(10, 0, 1); rd(9, 32'h0); fwd(0, 7, 32'h9090);
                                              push("hold_2",      32'h0, 0, 1, b(9), 0);
    tick(); issue(10, 0, 1); rd(9, 32'h0); fwd(0, 7, 32'h9090);
                                              push("resume_1",    32'h0, 0, 1, b(9), 0);
    tick(); issue(10, 0, 1); rd(9, 32'h0); fwd(0, 7, 32'h9090);
                                              push("resume_2",    32'h0, 0, 1, b(9), 0);
    tick(); issue(10, 0, 1); rd(9, 32'h0); fwd(0, 7, 32'h9090);
                                              push("resume_fwd",  32'h9090, 1, 0, b(9), 0);
    tick();                                   push("final",       32'h0, 1, 0, b(9) | b(10), 1);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain queue has %0d entries want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
